ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 8'hED set-LEDs, 8'hFF reset)
//  to the keyboard over the open-drain PS2_CLK/PS2_DAT lines. Sits beside the keyboard receiver.
//  The keyboard receiver must ignore the bus while busy=1.

---
 rtl/ps2_pkg.sv | 37 +++
 rtl/ps2_line_sync.sv | 33 +++
 rtl/ps2_host_tx.sv | 171 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 host-transmit types: FSM states, frame layout, timing defaults and command bytes.
package ps2_pkg;

  localparam int unsigned PS2_INHIBIT_CYCLES = 6000;
  localparam int unsigned PS2_TIMEOUT_CYCLES = 750000;
  localparam int unsigned PS2_FRAME_W        = 9;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_DATA,
    ST_STOP,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_DONE,
    ST_ERROR
  } ps2_tx_state_e;

  // Bits leave the host LSB first: data[0] is frame bit 0, parity is frame bit 8.
  typedef struct packed {
    logic       parity;
    logic [7:0] data;
  } ps2_frame_t;

  function automatic ps2_frame_t ps2_make_frame(input logic [7:0] data);
    ps2_frame_t f;
    f.parity = ~^data;
    f.data   = data;
    return f;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronisers for the raw PS/2 clock and data pins, plus a one-cycle
// strobe when the synchronised clock falls.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_pin,
  input  logic dat_pin,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic clk_meta;
  logic dat_meta;

  // Reset to the idle-bus level so leaving reset never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
      clk_fall <= 1'b0;
    end else begin
      clk_meta <= clk_pin;
      clk_sync <= clk_meta;
      dat_meta <= dat_pin;
      dat_sync <= dat_meta;
      clk_fall <= clk_sync & ~clk_meta;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (open-drain enables; the board wrapper ties
// PS2_CLK/PS2_DAT to 1'b0 when the matching _oe is 1, else 1'bz).
// Optional watchdog: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES
`ifdef PS2_TX_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
`endif
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned BIT_W = $clog2(PS2_FRAME_W);
`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
`endif

  ps2_tx_state_e            state;
  ps2_frame_t               frame;
  logic [PS2_FRAME_W-1:0]   frame_bits;
  logic [BIT_W-1:0]         bit_cnt;
  logic [INH_W-1:0]         inhibit_cnt;
  logic                     clk_sync;
  logic                     dat_sync;
  logic                     clk_fall;
`ifdef PS2_TX_TIMEOUT_EN
  logic [WD_W-1:0]          wd_cnt;
`endif

  assign frame_bits = frame;

  ps2_line_sync u_sync (
    .clk      (CLOCK_50),
    .rst      (reset),
    .clk_pin  (ps2_clk_in),
    .dat_pin  (ps2_dat_in),
    .clk_sync (clk_sync),
    .dat_sync (dat_sync),
    .clk_fall (clk_fall)
  );

  // Transfer sequencer; every output is a register so the pins never glitch.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      frame       <= '0;
      bit_cnt     <= '0;
      inhibit_cnt <= '0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_dat_oe  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_cnt      <= '0;
`endif
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;

      case (state)
        ST_IDLE: begin
          inhibit_cnt <= '0;
          if (tx_valid) begin
            frame      <= ps2_make_frame(tx_data);
            state      <= ST_INHIBIT;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= 1'b0;
          end
        end

        ST_INHIBIT: begin
          if (inhibit_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
            state      <= ST_REQ;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b1;
            bit_cnt    <= '0;
          end else begin
            inhibit_cnt <= inhibit_cnt + INH_W'(1);
          end
        end

        // The request-to-send fall delivers data bit 0; later falls walk up to parity.
        ST_REQ, ST_DATA: begin
          if (clk_fall) begin
            ps2_dat_oe <= ~frame_bits[bit_cnt];
            bit_cnt    <= bit_cnt + BIT_W'(1);
            state      <= (bit_cnt == BIT_W'(PS2_FRAME_W - 1)) ? ST_STOP : ST_DATA;
          end
        end

        ST_STOP: begin
          if (clk_fall) begin
            ps2_dat_oe <= 1'b0;
            state      <= ST_ACK;
          end
        end

        ST_ACK: begin
          if (clk_fall) begin
            if (dat_sync) begin
              state      <= ST_ERROR;
              tx_error   <= 1'b1;
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= 1'b0;
            end else begin
              state <= ST_WAIT_IDLE;
            end
          end
        end

        ST_WAIT_IDLE: begin
          if (clk_sync && dat_sync) begin
            state   <= ST_DONE;
            tx_done <= 1'b1;
          end
        end

        ST_DONE, ST_ERROR: begin
          state    <= ST_IDLE;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
        end

        default: begin
          state      <= ST_IDLE;
          tx_ready   <= 1'b1;
          busy       <= 1'b0;
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
        end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // Watchdog wins over any same-cycle progress so done and error stay exclusive.
      if (state inside {ST_REQ, ST_DATA, ST_STOP, ST_ACK, ST_WAIT_IDLE}) begin
        if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state      <= ST_ERROR;
          tx_done    <= 1'b0;
          tx_error   <= 1'b1;
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          wd_cnt     <= '0;
        end else begin
          wd_cnt <= wd_cnt + WD_W'(1);
        end
      end else begin
        wd_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: models a PS/2 keyboard that clocks the host frame in and
// acknowledges it, checking frames against parity/ordering rules computed here.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned H   = 10;
  localparam int unsigned INH = 6000;
`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TMO = 3000;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_error;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  int done_total = 0, err_total = 0, both_total = 0, err_oe_bad = 0, ready_bad = 0;
  logic prev_pulse = 1'b0;

  logic [9:0] r_bits;
  int         r_inh_len, r_dones, r_errs;
  logic       r_req_ok, r_busy1, r_ready1, r_ready0, r_tmo;

  always #5 clk = ~clk;

  // Open-drain bus: either side may pull a line low.
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH)
`ifdef PS2_TX_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .CLOCK_50   (clk),
    .reset      (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  // Pulse bookkeeping observed every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_done) done_total++;
      if (tx_error) err_total++;
      if (tx_done && tx_error) both_total++;
      if (tx_error && (ps2_clk_oe || ps2_dat_oe)) err_oe_bad++;
      if (prev_pulse && !(tx_ready && !busy)) ready_bad++;
      prev_pulse = tx_done | tx_error;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  function automatic logic odd_parity(input logic [7:0] d);
    return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // Host request plus keyboard behaviour; stop_after>0 leaves the clock held low after that fall.
  task automatic run_transfer(input logic [7:0] d, input bit ack, input int stop_after);
    int n;
    int d0;
    int e0;
    r_tmo = 1'b0;
    r_bits = '0;
    d0 = done_total;
    e0 = err_total;
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    r_ready0 = tx_ready;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    r_busy1 = busy;
    r_ready1 = tx_ready;
    r_inh_len = 0;
    n = 0;
    while (ps2_clk_oe && n < int'(INH) + 100) begin
      r_inh_len++;
      n++;
      @(negedge clk);
    end
    r_req_ok = ps2_dat_oe && !ps2_clk_oe;
    n = 0;
    while (!(ps2_clk_in && !ps2_dat_in) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) r_tmo = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 1; i <= 11 && !r_tmo; i++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      if (i == stop_after) return;
      dev_clk_low = 1'b0;
      if (i <= 10) r_bits[i-1] = ps2_dat_in;
      if (i == 10 && ack) dev_dat_low = 1'b1;
      repeat (H) @(negedge clk);
    end
    dev_dat_low = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (busy) r_tmo = 1'b1;
    repeat (2) @(negedge clk);
    r_dones = done_total - d0;
    r_errs  = err_total - e0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin miscompares++; $display("FAIL reset_oe: got %b expected 00", {ps2_clk_oe, ps2_dat_oe}); end
    vectors++; if ({tx_done, tx_error} !== 2'b00) begin miscompares++; $display("FAIL reset_pulses: got %b expected 00", {tx_done, tx_error}); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if ({tx_ready, busy} !== 2'b10) begin miscompares++; $display("FAIL post_reset_idle: got %b expected 10", {tx_ready, busy}); end
  endtask

  task automatic test_inhibit_and_set_leds();
    logic [7:0] d;
    d = PS2_CMD_SET_LEDS;
    run_transfer(d, 1'b1, 0);
    vectors++; if (r_tmo !== 1'b0) begin miscompares++; $display("FAIL leds_timeout: got %b expected 0", r_tmo); end
    vectors++; if (r_ready0 !== 1'b1) begin miscompares++; $display("FAIL leds_ready_before: got %b expected 1", r_ready0); end
    vectors++; if ({r_busy1, r_ready1} !== 2'b10) begin miscompares++; $display("FAIL accept_latency busy/ready: got %b expected 10", {r_busy1, r_ready1}); end
    vectors++; if (r_inh_len != int'(INH)) begin miscompares++; $display("FAIL inhibit_len: got %0d expected %0d", r_inh_len, INH); end
    vectors++; if (r_req_ok !== 1'b1) begin miscompares++; $display("FAIL req_dat_oe_align: got %b expected 1", r_req_ok); end
    vectors++; if (r_bits !== 10'b11_1110_1101) begin miscompares++; $display("FAIL leds_frame: got %b expected 1111101101", r_bits); end
    vectors++; if (r_dones != 1 || r_errs != 0) begin miscompares++; $display("FAIL leds_pulses: got done=%0d err=%0d expected done=1 err=0", r_dones, r_errs); end
  endtask

  task automatic test_parity_patterns();
    logic [7:0] pats [3] = '{8'h00, 8'hFF, 8'h01};
    logic       pars [3] = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      run_transfer(pats[k], 1'b1, 0);
      vectors++; if (r_tmo !== 1'b0) begin miscompares++; $display("FAIL parity_timeout[%0h]: got %b expected 0", pats[k], r_tmo); end
      vectors++; if (r_bits[7:0] !== pats[k]) begin miscompares++; $display("FAIL parity_data[%0h]: got %h expected %h", pats[k], r_bits[7:0], pats[k]); end
      vectors++; if (r_bits[8] !== pars[k]) begin miscompares++; $display("FAIL parity_bit[%0h]: got %b expected %b", pats[k], r_bits[8], pars[k]); end
      vectors++; if (r_dones != 1) begin miscompares++; $display("FAIL parity_done[%0h]: got %0d expected 1", pats[k], r_dones); end
    end
  endtask

  task automatic test_random_bytes();
    logic [7:0] d;
    for (int k = 0; k < 2; k++) begin
      d = 8'($urandom);
      run_transfer(d, 1'b1, 0);
      vectors++; if (r_bits !== {1'b1, odd_parity(d), d}) begin miscompares++; $display("FAIL random_frame[%0h]: got %b expected %b", d, r_bits, {1'b1, odd_parity(d), d}); end
      vectors++; if (r_dones != 1 || r_errs != 0) begin miscompares++; $display("FAIL random_pulses[%0h]: got done=%0d err=%0d expected 1/0", d, r_dones, r_errs); end
    end
  endtask

  task automatic test_no_ack();
    int bad0;
    bad0 = err_oe_bad;
    run_transfer(PS2_CMD_RESET, 1'b0, 0);
    vectors++; if (r_errs != 1) begin miscompares++; $display("FAIL noack_error: got %0d expected 1", r_errs); end
    vectors++; if (r_dones != 0) begin miscompares++; $display("FAIL noack_done: got %0d expected 0", r_dones); end
    vectors++; if (err_oe_bad != bad0) begin miscompares++; $display("FAIL noack_lines_released: got %0d expected %0d", err_oe_bad, bad0); end
    vectors++; if ({tx_ready, busy} !== 2'b10) begin miscompares++; $display("FAIL noack_idle: got %b expected 10", {tx_ready, busy}); end
  endtask

  task automatic test_reset_mid_transfer();
    logic [7:0] d;
    d = 8'hA5;
    run_transfer(d, 1'b1, 4);
    vectors++; if (ps2_dat_oe !== 1'b1) begin miscompares++; $display("FAIL mid_bit3_driven: got %b expected 1", ps2_dat_oe); end
    rst = 1'b1;
    #1;
    vectors++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin miscompares++; $display("FAIL mid_reset_oe: got %b expected 00", {ps2_clk_oe, ps2_dat_oe}); end
    vectors++; if ({tx_ready, busy} !== 2'b10) begin miscompares++; $display("FAIL mid_reset_ready: got %b expected 10", {tx_ready, busy}); end
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    d = PS2_CMD_ENABLE;
    run_transfer(d, 1'b1, 0);
    vectors++; if (r_bits !== {1'b1, odd_parity(d), d}) begin miscompares++; $display("FAIL after_reset_frame: got %b expected %b", r_bits, {1'b1, odd_parity(d), d}); end
    vectors++; if (r_dones != 1 || r_errs != 0) begin miscompares++; $display("FAIL after_reset_pulses: got done=%0d err=%0d expected 1/0", r_dones, r_errs); end
  endtask

  task automatic test_silent_device();
    int n;
    int d0;
    int e0;
    int busy_low;
    d0 = done_total;
    e0 = err_total;
    @(negedge clk);
    tx_data = 8'($urandom);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe && n < int'(INH) + 100) begin n++; @(negedge clk); end
    vectors++; if (ps2_dat_oe !== 1'b1) begin miscompares++; $display("FAIL silent_req: got %b expected 1", ps2_dat_oe); end
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (!tx_error && n < int'(TMO) + 100) begin n++; @(negedge clk); end
    vectors++; if (n != int'(TMO)) begin miscompares++; $display("FAIL timeout_latency: got %0d expected %0d", n, TMO); end
    vectors++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin miscompares++; $display("FAIL timeout_oe: got %b expected 00", {ps2_clk_oe, ps2_dat_oe}); end
    repeat (3) @(negedge clk);
    vectors++; if (done_total - d0 != 0) begin miscompares++; $display("FAIL timeout_done: got %0d expected 0", done_total - d0); end
`else
    busy_low = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy) busy_low++;
    end
    vectors++; if (busy_low != 0) begin miscompares++; $display("FAIL silent_busy_dropped: got %0d expected 0", busy_low); end
    vectors++; if ((done_total - d0) + (err_total - e0) != 0) begin miscompares++; $display("FAIL silent_pulses: got %0d expected 0", (done_total - d0) + (err_total - e0)); end
    vectors++; if (ps2_dat_oe !== 1'b1) begin miscompares++; $display("FAIL silent_still_req: got %b expected 1", ps2_dat_oe); end
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_global_invariants();
    vectors++; if (both_total != 0) begin miscompares++; $display("FAIL done_error_overlap: got %0d expected 0", both_total); end
    vectors++; if (ready_bad != 0) begin miscompares++; $display("FAIL ready_after_pulse: got %0d expected 0", ready_bad); end
  endtask

  initial begin
    test_reset();
    test_inhibit_and_set_leds();
    test_parity_patterns();
    test_random_bytes();
    test_no_ack();
    test_reset_mid_transfer();
    test_silent_device();
    test_global_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
